dac_sample_packer: RTL and testbench



---
 rtl/dac_pkg.sv | 23 ++
 rtl/dac_lane_pack.sv | 51 +++++
 rtl/dac_sample_packer.sv | 234 +++++++++++++++++++++++
 tb/tb_dac_sample_packer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_pkg.sv
// Shared types and constants for the DAC sample packer: FSM state encoding,
// channel count and sample/packet widths.
package dac_pkg;

  localparam int unsigned CH_NUM = 8;
  localparam int unsigned SMP_W  = 16;
  localparam int unsigned PKT_W  = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    RUN   = 2'd2
  } state_e;

  typedef logic [SMP_W-1:0] smp_t;
  typedef logic [PKT_W-1:0] pkt_t;

  // Later sample goes to the upper half of the packed word.
  function automatic pkt_t pack_pair(input smp_t hi, input smp_t lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/dac_lane_pack.sv
// One channel of the packer: holds the first (low) sample of a pair and the
// packed output word; optionally substitutes a per-lane ramp value.
module dac_lane_pack
  import dac_pkg::*;
#(
  parameter int unsigned LANE = 0
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             cap_lo_i,
  input  logic             pack_i,
  input  logic             clr_i,
  input  logic             ramp_en_i,
  input  logic [SMP_W-1:0] ramp_base_i,
  input  logic [SMP_W-1:0] din_i,
  output logic [PKT_W-1:0] dout_o
);

  smp_t lo_q, lo_d;
  pkt_t out_q, out_d;
  smp_t ramp_lo;

  assign ramp_lo = ramp_base_i + smp_t'(LANE);

  always_comb begin
    lo_d  = lo_q;
    out_d = out_q;
    if (cap_lo_i) begin
      lo_d = din_i;
    end
    if (clr_i) begin
      out_d = '0;
    end else if (pack_i) begin
      out_d = ramp_en_i ? pack_pair(ramp_lo + smp_t'(1), ramp_lo)
                        : pack_pair(din_i, lo_q);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      lo_q  <= '0;
      out_q <= '0;
    end else begin
      lo_q  <= lo_d;
      out_q <= out_d;
    end
  end

  assign dout_o = out_q;

endmodule

// File: rtl/dac_sample_packer.sv
// Packs pairs of 16-bit samples per channel into 32-bit DAC words with an
// IDLE/ALIGN/RUN startup FSM, gap/overrun detection. Optional test ramp: DAC_PACKER_RAMP_EN.
module dac_sample_packer
  import dac_pkg::*;
#(
  parameter int unsigned SETTLE_CNT = 4,
  parameter int unsigned GAP_MAX    = 2
) (
  input  logic        clk_250m,
  input  logic        rst_250m_n,
  input  logic        tx_en,
  input  logic        dac_ready,
  input  logic        valid,
  input  logic [15:0] din0,
  input  logic [15:0] din1,
  input  logic [15:0] din2,
  input  logic [15:0] din3,
  input  logic [15:0] din4,
  input  logic [15:0] din5,
  input  logic [15:0] din6,
  input  logic [15:0] din7,
  output logic        dout_valid,
  output logic [31:0] dout0,
  output logic [31:0] dout1,
  output logic [31:0] dout2,
  output logic [31:0] dout3,
  output logic [31:0] dout4,
  output logic [31:0] dout5,
  output logic [31:0] dout6,
  output logic [31:0] dout7,
  output logic [15:0] frame_cnt,
  output logic        underflow,
  output logic        overrun,
  input  logic        err_clr,
  output logic [1:0]  state
`ifdef DAC_PACKER_RAMP_EN
  ,
  input  logic        ramp_sel
`endif
);

  state_e      state_q, state_d;
  logic        phase_q, phase_d;
  logic [3:0]  settle_q, settle_d;
  logic [2:0]  gap_q, gap_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        dv_q, dv_d;
  logic        uf_q, uf_d;
  logic        ov_q, ov_d;
  logic        valid_prev_q, valid_prev_d;

  logic        link_ok;
  logic        cap_lo, pack, clr, enter_run;
  logic        uf_set, ov_set;
  logic        ramp_en;
  smp_t        ramp_base;

  assign link_ok = tx_en && dac_ready;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    settle_d    = settle_q;
    gap_d       = gap_q;
    frame_cnt_d = frame_cnt_q;
    dv_d        = 1'b0;
    cap_lo      = 1'b0;
    pack        = 1'b0;
    clr         = 1'b0;
    enter_run   = 1'b0;
    uf_set      = 1'b0;

    // Link loss overrides every other transition; partial word is dropped.
    if (!link_ok) begin
      state_d  = IDLE;
      phase_d  = 1'b0;
      settle_d = '0;
      gap_d    = '0;
      clr      = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          state_d  = ALIGN;
          phase_d  = 1'b0;
          settle_d = '0;
          gap_d    = '0;
        end
        ALIGN: begin
          if (valid) begin
            if (settle_q == 4'(SETTLE_CNT - 1)) begin
              state_d   = RUN;
              settle_d  = '0;
              phase_d   = 1'b0;
              gap_d     = '0;
              enter_run = 1'b1;
            end else begin
              settle_d = settle_q + 4'd1;
            end
          end
        end
        RUN: begin
          if (valid) begin
            gap_d = '0;
            if (!phase_q) begin
              cap_lo  = 1'b1;
              phase_d = 1'b1;
            end else begin
              pack        = 1'b1;
              dv_d        = 1'b1;
              frame_cnt_d = frame_cnt_q + 16'd1;
              phase_d     = 1'b0;
            end
          end else if (gap_q == 3'(GAP_MAX)) begin
            uf_set   = 1'b1;
            state_d  = ALIGN;
            phase_d  = 1'b0;
            gap_d    = '0;
            settle_d = '0;
          end else begin
            gap_d = gap_q + 3'd1;
          end
        end
        default: begin
          state_d  = IDLE;
          phase_d  = 1'b0;
          settle_d = '0;
          gap_d    = '0;
          clr      = 1'b1;
        end
      endcase
    end

    ov_set       = valid && valid_prev_q && (state_q == ALIGN || state_q == RUN);
    valid_prev_d = valid && (state_q != IDLE);
    // A new error event takes priority over a simultaneous clear.
    uf_d = uf_set ? 1'b1 : (err_clr ? 1'b0 : uf_q);
    ov_d = ov_set ? 1'b1 : (err_clr ? 1'b0 : ov_q);
  end

  always_ff @(posedge clk_250m or negedge rst_250m_n) begin
    if (!rst_250m_n) begin
      state_q      <= IDLE;
      phase_q      <= 1'b0;
      settle_q     <= '0;
      gap_q        <= '0;
      frame_cnt_q  <= '0;
      dv_q         <= 1'b0;
      uf_q         <= 1'b0;
      ov_q         <= 1'b0;
      valid_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      settle_q     <= settle_d;
      gap_q        <= gap_d;
      frame_cnt_q  <= frame_cnt_d;
      dv_q         <= dv_d;
      uf_q         <= uf_d;
      ov_q         <= ov_d;
      valid_prev_q <= valid_prev_d;
    end
  end

`ifdef DAC_PACKER_RAMP_EN
  smp_t ramp_q, ramp_d;

  always_comb begin
    ramp_d = ramp_q;
    if (enter_run) begin
      ramp_d = '0;
    end else if (pack) begin
      ramp_d = ramp_q + smp_t'(2);
    end
  end

  always_ff @(posedge clk_250m or negedge rst_250m_n) begin
    if (!rst_250m_n) begin
      ramp_q <= '0;
    end else begin
      ramp_q <= ramp_d;
    end
  end

  assign ramp_en   = ramp_sel;
  assign ramp_base = ramp_q;
`else
  assign ramp_en   = 1'b0;
  assign ramp_base = '0;
`endif

  logic [SMP_W-1:0] din_a  [CH_NUM];
  logic [PKT_W-1:0] dout_a [CH_NUM];

  assign din_a[0] = din0;
  assign din_a[1] = din1;
  assign din_a[2] = din2;
  assign din_a[3] = din3;
  assign din_a[4] = din4;
  assign din_a[5] = din5;
  assign din_a[6] = din6;
  assign din_a[7] = din7;

  for (genvar k = 0; k < CH_NUM; k++) begin : g_lane
    dac_lane_pack #(
      .LANE(k)
    ) u_lane (
      .clk_i       (clk_250m),
      .rst_n_i     (rst_250m_n),
      .cap_lo_i    (cap_lo),
      .pack_i      (pack),
      .clr_i       (clr),
      .ramp_en_i   (ramp_en),
      .ramp_base_i (ramp_base),
      .din_i       (din_a[k]),
      .dout_o      (dout_a[k])
    );
  end

  assign dout0 = dout_a[0];
  assign dout1 = dout_a[1];
  assign dout2 = dout_a[2];
  assign dout3 = dout_a[3];
  assign dout4 = dout_a[4];
  assign dout5 = dout_a[5];
  assign dout6 = dout_a[6];
  assign dout7 = dout_a[7];

  assign dout_valid = dv_q;
  assign frame_cnt  = frame_cnt_q;
  assign underflow  = uf_q;
  assign overrun    = ov_q;
  assign state      = state_q;

endmodule

// File: tb/tb_dac_sample_packer.sv
// Directed bench for dac_sample_packer: cycle table for startup/packing/underflow
// plus hand sequences for errors, link drop, counter wrap, ramp and reset.
module tb_dac_sample_packer;

  localparam logic [1:0] S_I = 2'd0;
  localparam logic [1:0] S_A = 2'd1;
  localparam logic [1:0] S_R = 2'd2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tx_en, dac_ready, valid, err_clr, ramp_sel;
  logic [15:0] din  [8];
  logic [31:0] dout [8];
  logic        dout_valid, underflow, overrun;
  logic [15:0] frame_cnt;
  logic [1:0]  state;

  int n_tests = 0;
  int n_fail  = 0;

  always #2 clk = ~clk;

  dac_sample_packer #(
    .SETTLE_CNT(4),
    .GAP_MAX   (2)
  ) dut (
    .clk_250m   (clk),
    .rst_250m_n (rst_n),
    .tx_en      (tx_en),
    .dac_ready  (dac_ready),
    .valid      (valid),
    .din0       (din[0]),
    .din1       (din[1]),
    .din2       (din[2]),
    .din3       (din[3]),
    .din4       (din[4]),
    .din5       (din[5]),
    .din6       (din[6]),
    .din7       (din[7]),
    .dout_valid (dout_valid),
    .dout0      (dout[0]),
    .dout1      (dout[1]),
    .dout2      (dout[2]),
    .dout3      (dout[3]),
    .dout4      (dout[4]),
    .dout5      (dout[5]),
    .dout6      (dout[6]),
    .dout7      (dout[7]),
    .frame_cnt  (frame_cnt),
    .underflow  (underflow),
    .overrun    (overrun),
    .err_clr    (err_clr),
    .state      (state)
`ifdef DAC_PACKER_RAMP_EN
    ,
    .ramp_sel   (ramp_sel)
`endif
  );

  typedef struct {
    logic        en, rdy, v, clr;
    logic [15:0] d;
    logic [1:0]  st;
    logic        dv;
    logic [31:0] d0;
    logic [15:0] fc;
    logic        uf, ov;
  } vec_t;

  vec_t tbl [32];

  function automatic vec_t mk(logic v, logic [15:0] d, logic [1:0] st, logic dv,
                              logic [31:0] d0, logic [15:0] fc, logic uf);
    vec_t r;
    r.en = 1'b1; r.rdy = 1'b1; r.v = v; r.clr = 1'b0; r.d = d;
    r.st = st; r.dv = dv; r.d0 = d0; r.fc = fc; r.uf = uf; r.ov = 1'b0;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Lane k carries din0 + k*0x100, so expected lane words follow from lane 0.
  task automatic check_all(input string tag, input logic [1:0] st, input logic dv,
                           input logic [31:0] d0, input logic [15:0] fc,
                           input logic uf, input logic ov);
    logic [31:0] e;
    chk({tag, " state"}, 32'(state), 32'(st));
    chk({tag, " dout_valid"}, 32'(dout_valid), 32'(dv));
    chk({tag, " frame_cnt"}, 32'(frame_cnt), 32'(fc));
    chk({tag, " underflow"}, 32'(underflow), 32'(uf));
    chk({tag, " overrun"}, 32'(overrun), 32'(ov));
    for (int k = 0; k < 8; k++) begin
      e = (d0 == 32'd0) ? 32'd0 : d0 + 32'(k) * 32'h0100_0100;
      chk($sformatf("%s dout%0d", tag, k), dout[k], e);
    end
  endtask

  task automatic step(input logic en, input logic rdy, input logic v,
                      input logic clr, input logic [15:0] d);
    tx_en = en; dac_ready = rdy; valid = v; err_clr = clr;
    for (int k = 0; k < 8; k++) din[k] = d + 16'(k * 256);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; tx_en = 1'b0; dac_ready = 1'b0; valid = 1'b0;
    err_clr = 1'b0; ramp_sel = 1'b0;
    for (int k = 0; k < 8; k++) din[k] = '0;

    tbl[0]  = mk(0, 16'd0,  S_A, 0, 32'h0, 16'd0, 0);
    tbl[1]  = mk(1, 16'd1,  S_A, 0, 32'h0, 16'd0, 0);
    tbl[2]  = mk(0, 16'd0,  S_A, 0, 32'h0, 16'd0, 0);
    tbl[3]  = mk(1, 16'd2,  S_A, 0, 32'h0, 16'd0, 0);
    tbl[4]  = mk(0, 16'd0,  S_A, 0, 32'h0, 16'd0, 0);
    tbl[5]  = mk(1, 16'd3,  S_A, 0, 32'h0, 16'd0, 0);
    tbl[6]  = mk(0, 16'd0,  S_A, 0, 32'h0, 16'd0, 0);
    tbl[7]  = mk(1, 16'd4,  S_R, 0, 32'h0, 16'd0, 0);
    tbl[8]  = mk(0, 16'd0,  S_R, 0, 32'h0, 16'd0, 0);
    tbl[9]  = mk(1, 16'd5,  S_R, 0, 32'h0, 16'd0, 0);
    tbl[10] = mk(0, 16'd0,  S_R, 0, 32'h0, 16'd0, 0);
    tbl[11] = mk(1, 16'd6,  S_R, 1, 32'h0006_0005, 16'd1, 0);
    tbl[12] = mk(0, 16'd0,  S_R, 0, 32'h0006_0005, 16'd1, 0);
    tbl[13] = mk(1, 16'd7,  S_R, 0, 32'h0006_0005, 16'd1, 0);
    tbl[14] = mk(0, 16'd0,  S_R, 0, 32'h0006_0005, 16'd1, 0);
    tbl[15] = mk(1, 16'd8,  S_R, 1, 32'h0008_0007, 16'd2, 0);
    tbl[16] = mk(0, 16'd0,  S_R, 0, 32'h0008_0007, 16'd2, 0);
    tbl[17] = mk(1, 16'd9,  S_R, 0, 32'h0008_0007, 16'd2, 0);
    tbl[18] = mk(0, 16'd0,  S_R, 0, 32'h0008_0007, 16'd2, 0);
    tbl[19] = mk(0, 16'd0,  S_R, 0, 32'h0008_0007, 16'd2, 0);
    tbl[20] = mk(0, 16'd0,  S_A, 0, 32'h0008_0007, 16'd2, 1);
    tbl[21] = mk(1, 16'd10, S_A, 0, 32'h0008_0007, 16'd2, 1);
    tbl[22] = mk(0, 16'd0,  S_A, 0, 32'h0008_0007, 16'd2, 1);
    tbl[23] = mk(1, 16'd11, S_A, 0, 32'h0008_0007, 16'd2, 1);
    tbl[24] = mk(0, 16'd0,  S_A, 0, 32'h0008_0007, 16'd2, 1);
    tbl[25] = mk(1, 16'd12, S_A, 0, 32'h0008_0007, 16'd2, 1);
    tbl[26] = mk(0, 16'd0,  S_A, 0, 32'h0008_0007, 16'd2, 1);
    tbl[27] = mk(1, 16'd13, S_R, 0, 32'h0008_0007, 16'd2, 1);
    tbl[28] = mk(0, 16'd0,  S_R, 0, 32'h0008_0007, 16'd2, 1);
    tbl[29] = mk(1, 16'd14, S_R, 0, 32'h0008_0007, 16'd2, 1);
    tbl[30] = mk(0, 16'd0,  S_R, 0, 32'h0008_0007, 16'd2, 1);
    tbl[31] = mk(1, 16'd15, S_R, 1, 32'h000F_000E, 16'd3, 1);

    repeat (3) @(posedge clk);
    #1;
    check_all("reset", S_I, 0, 32'h0, 16'd0, 0, 0);
    rst_n = 1'b1;
    step(0, 0, 0, 0, 16'd0);
    check_all("idle", S_I, 0, 32'h0, 16'd0, 0, 0);

    for (int i = 0; i < 32; i++) begin
      step(tbl[i].en, tbl[i].rdy, tbl[i].v, tbl[i].clr, tbl[i].d);
      check_all($sformatf("vec%0d", i), tbl[i].st, tbl[i].dv, tbl[i].d0,
                tbl[i].fc, tbl[i].uf, tbl[i].ov);
    end

    // Overrun with packing continuing, clear, and set-beats-clear.
    step(1, 1, 0, 0, 16'd0);
    step(1, 1, 1, 0, 16'd16);
    check_all("ovr_a", S_R, 0, 32'h000F_000E, 16'd3, 1, 0);
    step(1, 1, 1, 0, 16'd17);
    check_all("ovr_b", S_R, 1, 32'h0011_0010, 16'd4, 1, 1);
    step(1, 1, 0, 1, 16'd0);
    check_all("clr", S_R, 0, 32'h0011_0010, 16'd4, 0, 0);
    step(1, 1, 1, 0, 16'd18);
    step(1, 1, 1, 1, 16'd19);
    check_all("set_wins", S_R, 1, 32'h0013_0012, 16'd5, 0, 1);
    step(1, 1, 0, 0, 16'd0);
    chk("ovr_sticky", 32'(overrun), 32'd1);
    step(1, 1, 0, 1, 16'd0);
    chk("ovr_clr2", 32'(overrun), 32'd0);

    // Link drop after a low-half capture.
    step(1, 1, 1, 0, 16'd20);
    step(1, 0, 0, 0, 16'd0);
    check_all("drop", S_I, 0, 32'h0, 16'd5, 0, 0);
    step(1, 0, 1, 0, 16'd21);
    check_all("drop_hold", S_I, 0, 32'h0, 16'd5, 0, 0);

    // Re-align, then preload the word counter near wrap.
    step(1, 1, 0, 0, 16'd0);
    chk("realign", 32'(state), 32'(S_A));
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 1, 0, 16'(30 + i));
      if (i < 3) step(1, 1, 0, 0, 16'd0);
    end
    chk("rerun", 32'(state), 32'(S_R));
    force dut.frame_cnt_q = 16'hFFFE;
    step(1, 1, 0, 0, 16'd0);
    release dut.frame_cnt_q;
    step(1, 1, 1, 0, 16'd40);
    step(1, 1, 0, 0, 16'd0);
    step(1, 1, 1, 0, 16'd41);
    check_all("wrap_a", S_R, 1, 32'h0029_0028, 16'hFFFF, 0, 0);
    step(1, 1, 0, 0, 16'd0);
    step(1, 1, 1, 0, 16'd42);
    step(1, 1, 0, 0, 16'd0);
    step(1, 1, 1, 0, 16'd43);
    check_all("wrap_b", S_R, 1, 32'h002B_002A, 16'h0000, 0, 0);

`ifdef DAC_PACKER_RAMP_EN
    step(1, 0, 0, 0, 16'd0);
    step(1, 1, 0, 0, 16'd0);
    ramp_sel = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 1, 0, 16'h1234);
      step(1, 1, 0, 0, 16'd0);
    end
    step(1, 1, 1, 0, 16'h1234);
    step(1, 1, 0, 0, 16'd0);
    step(1, 1, 1, 0, 16'h5678);
    chk("ramp_dv0", 32'(dout_valid), 32'd1);
    chk("ramp_w0_l0", dout[0], 32'h0001_0000);
    chk("ramp_w0_l7", dout[7], 32'h0008_0007);
    step(1, 1, 0, 0, 16'd0);
    step(1, 1, 1, 0, 16'h1234);
    step(1, 1, 0, 0, 16'd0);
    step(1, 1, 1, 0, 16'h5678);
    chk("ramp_w1_l0", dout[0], 32'h0003_0002);
    chk("ramp_w1_l7", dout[7], 32'h000A_0009);
    ramp_sel = 1'b0;
`endif

    // Asynchronous reset in the middle of a word.
    step(1, 1, 0, 0, 16'd0);
    step(1, 1, 1, 0, 16'd50);
    #1;
    rst_n = 1'b0;
    #1;
    check_all("rst_mid", S_I, 0, 32'h0, 16'd0, 0, 0);
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
